// File: rtl/div_pkg.sv
// Shared types and constants for the divider operand sequencer.
package div_pkg;

  localparam int DIV_WIDTH = 10;
  localparam int DIV_DEPTH = 4;

  // Quotient reported for a bypassed divide-by-zero; sliced to WIDTH by users.
  localparam logic [63:0] DIV_BYPASS_Q = {64{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Stream and divider-side signals of div_sequencer; master is the sequencer, slave its environment.
interface div_sequencer_if #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic                     div_start;
  logic [WIDTH-1:0]         div_a;
  logic [WIDTH-1:0]         div_b;
  logic                     div_busy;
  logic                     div_valid;
  logic [WIDTH-1:0]         div_q;
  logic                     div_ov;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_q;
  logic                     out_ov;
  logic [$clog2(DEPTH):0]   pending;

  modport master (
    input  in_valid, in_a, in_b, div_busy, div_valid, div_q, div_ov, out_ready,
    output in_ready, div_start, div_a, div_b, out_valid, out_q, out_ov, pending
  );

  modport slave (
    output in_valid, in_a, in_b, div_busy, div_valid, div_q, div_ov, out_ready,
    input  in_ready, div_start, div_a, div_b, out_valid, out_q, out_ov, pending
  );
endinterface

// File: rtl/div_seq_fifo.sv
// Operand FIFO holding {a, b} pairs; a push into a full FIFO succeeds when a pop happens in the same cycle.
module div_seq_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [2*WIDTH-1:0]     wdata,
  output logic [2*WIDTH-1:0]     rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [2*WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]      wr_ptr_r;
  logic [AW-1:0]      rd_ptr_r;
  logic [CW-1:0]      count_r;
  logic               do_push_s;
  logic               do_pop_s;

  // Qualify push/pop against occupancy.
  always_comb begin
    do_pop_s  = pop && (count_r != {CW{1'b0}});
    do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(2*WIDTH){1'b0}};
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = (count_r == FULL_CNT);
  assign empty = (count_r == {CW{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/div_sequencer.sv
// Feeds buffered operand pairs to a multi-cycle divider one at a time and returns results in order.
// Optional DIV_SEQ_ZERO_BYPASS_EN: zero divisors skip the divider and return all-ones with ov set.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int DEPTH = DIV_DEPTH
) (
  input logic            clk,
  input logic            rst,
  div_sequencer_if.master bus
);
  logic [2*WIDTH-1:0]     head_s;
  logic [WIDTH-1:0]       head_a_s;
  logic [WIDTH-1:0]       head_b_s;
  logic                   full_s;
  logic                   empty_s;
  logic [$clog2(DEPTH):0] count_s;
  logic                   in_ready_s;
  logic                   push_s;

  div_state_e       state_r;
  div_state_e       state_s;
  logic             pop_s;
  logic             latch_s;
  logic             capture_s;
  logic             bypass_s;

  logic             div_start_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] div_a_r;
  logic [WIDTH-1:0] div_b_r;
  logic [WIDTH-1:0] out_q_r;
  logic             out_ov_r;

  // A pop frees a slot in the same cycle, so a full FIFO still accepts then.
  assign in_ready_s = !full_s || pop_s;
  assign push_s     = bus.in_valid && in_ready_s;
  assign head_a_s   = head_s[2*WIDTH-1:WIDTH];
  assign head_b_s   = head_s[WIDTH-1:0];

  div_seq_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata ({bus.in_a, bus.in_b}),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Next-state and per-cycle control decode.
  always_comb begin
    state_s   = state_r;
    pop_s     = 1'b0;
    latch_s   = 1'b0;
    capture_s = 1'b0;
    bypass_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
`ifdef DIV_SEQ_ZERO_BYPASS_EN
          if (head_b_s == {WIDTH{1'b0}}) begin
            state_s  = HOLD;
            pop_s    = 1'b1;
            bypass_s = 1'b1;
          end else if (!bus.div_busy) begin
            state_s = ISSUE;
            latch_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
`else
          if (!bus.div_busy) begin
            state_s = ISSUE;
            latch_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
`endif
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (bus.div_valid) begin
          state_s   = HOLD;
          pop_s     = 1'b1;
          capture_s = 1'b1;
        end else begin
          state_s = WAIT;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State and registered outputs; operands stay put until the next issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      div_start_r <= 1'b0;
      out_valid_r <= 1'b0;
      div_a_r     <= {WIDTH{1'b0}};
      div_b_r     <= {WIDTH{1'b0}};
      out_q_r     <= {WIDTH{1'b0}};
      out_ov_r    <= 1'b0;
    end else begin
      state_r     <= state_s;
      div_start_r <= (state_s == ISSUE);
      out_valid_r <= (state_s == HOLD);
      if (latch_s) begin
        div_a_r <= head_a_s;
        div_b_r <= head_b_s;
      end
      if (capture_s) begin
        out_q_r  <= bus.div_q;
        out_ov_r <= bus.div_ov;
      end else if (bypass_s) begin
        out_q_r  <= DIV_BYPASS_Q[WIDTH-1:0];
        out_ov_r <= 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.div_start = div_start_r;
  assign bus.div_a     = div_a_r;
  assign bus.div_b     = div_b_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_q     = out_q_r;
  assign bus.out_ov    = out_ov_r;
  assign bus.pending   = count_s;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a 12-cycle divider model and an in-order result scoreboard.
module tb_div_sequencer;
  localparam int W = 10;
  localparam int D = 4;

  typedef struct packed {
    logic [W-1:0] q;
    logic         ov;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  div_sequencer_if #(.WIDTH(W), .DEPTH(D)) bus ();

  div_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks  = 0;
  int n_errors  = 0;
  int n_results = 0;
  int n_starts  = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t exp_div(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    if (b == '0) begin
      e.q  = '1;
      e.ov = 1'b1;
    end else begin
      e.q  = a / b;
      e.ov = 1'b0;
    end
    return e;
  endfunction

  // Divider model: busy for 12 cycles after start, then a one-cycle valid.
  int           m_cnt   = 0;
  logic         m_busy  = 1'b0;
  logic         m_valid = 1'b0;
  logic [W-1:0] m_q     = '0;
  logic         m_ov    = 1'b0;
  logic [W-1:0] ma      = '0;
  logic [W-1:0] mb      = '0;
  bit           skip_stab = 1'b0;
  bit           late_seen = 1'b0;

  assign bus.div_busy  = m_busy;
  assign bus.div_valid = m_valid;
  assign bus.div_q     = m_q;
  assign bus.div_ov    = m_ov;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_q     <= (mb == '0) ? '1 : ma / mb;
        m_ov    <= (mb == '0);
      end
    end
    if (bus.div_start) begin
      m_cnt  <= 12;
      m_busy <= 1'b1;
      ma     <= bus.div_a;
      mb     <= bus.div_b;
    end
  end

  // Start counter, operand stability at result time, and scoreboard.
  always @(negedge clk) begin
    if (bus.div_start) n_starts++;
    if (m_valid) begin
      late_seen = 1'b1;
      if (!skip_stab) begin
        chk("div_a_stable", bus.div_a, ma);
        chk("div_b_stable", bus.div_b, mb);
      end
    end
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", sb.size(), 1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_q", bus.out_q, e.q);
        chk("out_ov", bus.out_ov, e.ov);
        n_results++;
      end
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    waited       = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    chk("push_accept", bus.in_ready, 1);
    if (bus.in_ready) sb.push_back(exp_div(a, b));
    @(posedge clk);
    #1;
  endtask

  task automatic wait_results(input int target, input int budget);
    int k = 0;
    while (n_results < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("result_count", n_results, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int s0;
    int bad;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_div_start", bus.div_start, 0);
    chk("rst_div_a", bus.div_a, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_q", bus.out_q, 0);
    chk("rst_pending", bus.pending, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single operation: issue timing and operands.
    bus.out_ready = 1'b1;
    push(10'd32, 10'd16, w);
    chk("t1_pending", bus.pending, 1);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t1_start_hi", bus.div_start, 1);
    chk("t1_div_a", bus.div_a, 32);
    chk("t1_div_b", bus.div_b, 16);
    @(posedge clk); #1;
    chk("t1_start_lo", bus.div_start, 0);
    wait_results(1, 40);
    chk("t1_pending_end", bus.pending, 0);
    chk("t1_starts", n_starts, 1);

    // Divide by zero.
    s0 = n_starts;
    push(10'd32, 10'd0, w);
    bus.in_valid = 1'b0;
`ifdef DIV_SEQ_ZERO_BYPASS_EN
    wait_results(2, 2);
    chk("t2_no_start", n_starts, s0);
`else
    wait_results(2, 40);
    chk("t2_start", n_starts, s0 + 1);
`endif

    // Fill the FIFO while the divider is busy; fifth push lands on the first pop.
    push(10'd100, 10'd7, w);
    push(10'd50, 10'd5, w);
    push(10'd1023, 10'd1, w);
    push(10'd9, 10'd10, w);
    chk("t3_pending_full", bus.pending, 4);
    @(negedge clk);
    chk("t3_in_ready_lo", bus.in_ready, 0);
    push(10'd200, 10'd3, w);
    chk("t3_blocked", (w > 0), 1);
    chk("t3_pending_pushpop", bus.pending, 4);
    bus.in_valid = 1'b0;
    wait_results(7, 120);
    chk("t3_pending_end", bus.pending, 0);

    // Consumer backpressure for 20 cycles.
    bus.out_ready = 1'b0;
    push(10'd60, 10'd4, w);
    push(10'd70, 10'd7, w);
    bus.in_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!bus.out_valid && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("t4_out_valid", bus.out_valid, 1);
    s0  = n_starts;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_q !== 10'd15 || bus.div_start) bad++;
    end
    chk("t4_hold_bad_cycles", bad, 0);
    chk("t4_no_start", n_starts, s0);
    chk("t4_pending", bus.pending, 1);
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_out_valid_lo", bus.out_valid, 0);
    chk("t4_start_lo", bus.div_start, 0);
    @(posedge clk); #1;
    chk("t4_start_hi", bus.div_start, 1);
    chk("t4_div_a", bus.div_a, 70);
    wait_results(9, 40);

    // Asynchronous reset during WAIT with three entries queued.
    push(10'd90, 10'd9, w);
    push(10'd80, 10'd8, w);
    push(10'd70, 10'd5, w);
    bus.in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("t5_pending_pre", bus.pending, 3);
    skip_stab = 1'b1;
    late_seen = 1'b0;
    rst = 1'b0;
    #1;
    chk("t5_div_start", bus.div_start, 0);
    chk("t5_div_a", bus.div_a, 0);
    chk("t5_div_b", bus.div_b, 0);
    chk("t5_out_valid", bus.out_valid, 0);
    chk("t5_out_q", bus.out_q, 0);
    chk("t5_out_ov", bus.out_ov, 0);
    chk("t5_pending", bus.pending, 0);
    chk("t5_in_ready", bus.in_ready, 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    s0  = n_starts;
    bad = 0;
    repeat (25) begin
      @(negedge clk);
      if (bus.out_valid) bad++;
    end
    chk("t5_late_valid_seen", late_seen, 1);
    chk("t5_no_out_valid", bad, 0);
    chk("t5_no_start", n_starts, s0);
    chk("t5_results", n_results, 9);
    skip_stab = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
